// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD display types, constants and load-clamp helper.
`default_nettype none

package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam bcd_t BCD_BLANK = 4'hF;

  // Non-decimal load nibbles saturate to 9 rather than being masked.
  function automatic bcd_t bcd_clamp(input bcd_t n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_scan_counter_if.sv
// bcd_scan_counter_if: control/load inputs and count/display outputs of the scanning BCD counter.
`default_nettype none

interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  carry;
  logic [3:0]            bcd;
  logic [DIGITS-1:0]     dig_sel;

  modport master (
    output en, up, clr, load, load_val,
    input  count, carry, bcd, dig_sel
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, carry, bcd, dig_sel
  );
endinterface

`default_nettype wire

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD digit with wrap-around increment/decrement and ripple carry/borrow out.
`default_nettype none

module bcd_digit
  import bcd_disp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic ci,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic co
);

  bcd_t r_q;
  logic w_at_max;
  logic w_at_zero;

  assign w_at_max  = (r_q == BCD_MAX);
  assign w_at_zero = (r_q == 4'd0);

  // co is only meaningful when this digit actually steps, hence the ci gate.
  assign co = ci & ((inc & w_at_max) | (dec & w_at_zero));
  assign q  = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (ci & inc) begin
      r_q <= w_at_max ? 4'd0 : r_q + 4'd1;
    end else if (ci & dec) begin
      r_q <= w_at_zero ? BCD_MAX : r_q - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled multi-digit BCD up/down counter with a multiplexed digit scanner.
// Optional macro BCD_SCAN_LEADING_ZERO_BLANK_EN blanks leading-zero digits on bcd.
`default_nettype none

module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_scan_counter_if.slave  bus
);

  localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IW = $clog2(DIGITS);

  localparam logic [c_PW-1:0]   c_PRE_MAX  = c_PW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0]   c_SCAN_MAX = c_SW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0]   c_IDX_MAX  = c_IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_SEL_RST  = DIGITS'(1);

  // ---------------- prescaler ----------------
  logic [c_PW-1:0] r_pre;
  logic            w_tick;
  logic            w_ld;

  assign w_tick = bus.en & (r_pre == c_PRE_MAX);
  assign w_ld   = bus.clr | bus.load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_ld) begin
      r_pre <= '0;
    end else if (bus.en) begin
      r_pre <= w_tick ? '0 : r_pre + c_PW'(1);
    end
  end

  // ---------------- digit chain ----------------
  logic [4*DIGITS-1:0] w_count;
  logic [DIGITS:0]     w_chain;

  assign w_chain[0] = w_tick;

  // Clear is folded into the digit load path so load/tick priority lives in one place.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_t w_d;
    assign w_d = bus.clr ? 4'd0 : bcd_clamp(bus.load_val[4*i +: 4]);

    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.up),
      .dec   (~bus.up),
      .ci    (w_chain[i]),
      .load  (w_ld),
      .d     (w_d),
      .q     (w_count[4*i +: 4]),
      .co    (w_chain[i+1])
    );
  end

  logic r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= ~w_ld & w_chain[DIGITS];
    end
  end

  // ---------------- scanner ----------------
  logic [c_SW-1:0]   r_scan;
  logic [c_IW-1:0]   r_idx;
  logic [DIGITS-1:0] r_dig_sel;
  bcd_t              r_bcd;

  logic              w_scan_wrap;
  logic [c_IW-1:0]   w_idx_nxt;
  logic [DIGITS-1:0] w_sel_nxt;
  bcd_t              w_nib;
  bcd_t              w_bcd_nxt;

  assign w_scan_wrap = (r_scan == c_SCAN_MAX);
  assign w_idx_nxt   = !w_scan_wrap          ? r_idx :
                       (r_idx == c_IDX_MAX)  ? '0    : r_idx + c_IW'(1);
  assign w_sel_nxt   = c_SEL_RST << w_idx_nxt;

  // Select and code are both derived from the next index so they change on the same edge.
  always_comb begin
    w_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == c_IW'(i)) begin
        w_nib = w_count[4*i +: 4];
      end
    end
  end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic w_blank;

  always_comb begin
    w_blank = (w_idx_nxt != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(w_idx_nxt)) && (w_count[4*j +: 4] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end

  assign w_bcd_nxt = w_blank ? BCD_BLANK : w_nib;
`else
  assign w_bcd_nxt = w_nib;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan    <= '0;
      r_idx     <= '0;
      r_dig_sel <= c_SEL_RST;
      r_bcd     <= '0;
    end else begin
      r_scan    <= w_scan_wrap ? '0 : r_scan + c_SW'(1);
      r_idx     <= w_idx_nxt;
      r_dig_sel <= w_sel_nxt;
      r_bcd     <= w_bcd_nxt;
    end
  end

  assign bus.count   = w_count;
  assign bus.carry   = r_carry;
  assign bus.bcd     = r_bcd;
  assign bus.dig_sel = r_dig_sel;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: randomized + directed scoreboard bench against a decimal reference model.
// Honours BCD_SCAN_LEADING_ZERO_BLANK_EN for the expected scanner code.
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_scan_counter;

  localparam int D   = 4;
  localparam int TD  = 4;
  localparam int SD  = 2;
  localparam int MOD = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_counter_if #(.DIGITS(D)) bus ();

  bcd_scan_counter #(
    .DIGITS   (D),
    .TICK_DIV (TD),
    .SCAN_DIV (SD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] count;
    logic        carry;
    logic [3:0]  bcd;
    logic [3:0]  sel;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference state: the count as a plain decimal integer, prescaler phase, edges since reset.
  int m_count = 0;
  int m_pre   = 0;
  int m_edges = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int dec_of_load(input logic [15:0] v);
    int r;
    int n;
    r = 0;
    for (int i = 0; i < D; i++) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      r = r + n * p10(i);
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  task automatic step(input logic e, input logic u, input logic c, input logic l,
                      input logic [15:0] lv);
    exp_t x;
    int   idx;
    logic tick;
    @(negedge clk);
    bus.en       = e;
    bus.up       = u;
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = lv;

    m_edges++;
    idx   = (m_edges / SD) % D;
    x.sel = 4'(1 << idx);
    x.bcd = 4'((m_count / p10(idx)) % 10);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (idx > 0 && m_count < p10(idx)) x.bcd = 4'hF;
`endif

    tick    = e && (m_pre == TD - 1);
    x.carry = 1'b0;
    if (c) begin
      m_count = 0;
      m_pre   = 0;
    end else if (l) begin
      m_count = dec_of_load(lv);
      m_pre   = 0;
    end else begin
      if (e) m_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
        if (u) begin
          x.carry = (m_count == MOD - 1);
          m_count = (m_count + 1) % MOD;
        end else begin
          x.carry = (m_count == 0);
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
    end
    x.count = to_bcd(m_count);
    sb.push_back(x);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_bcd", bus.bcd, 0);
    chk("rst_dig_sel", bus.dig_sel, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    m_count = 0;
    m_pre   = 0;
    m_edges = 0;
  endtask

  // Monitor: every clock edge with rst_n high is an output event.
  always begin : mon
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("count", bus.count, x.count);
      chk("carry", bus.carry, x.carry);
      chk("bcd", bus.bcd, x.bcd);
      chk("dig_sel", bus.dig_sel, x.sel);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] lv;
    logic        dir;
    int          r;
    bus.en = 0; bus.up = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0;

    do_reset();

    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 16'h0);
    settle();
    chk("count_40_cycles", bus.count, 16'h0010);

    step(1, 1, 0, 1, 16'h9998);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 16'h0);
    settle();
    chk("wrap_up_count", bus.count, 16'h0000);
    chk("wrap_up_carry", bus.carry, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 16'h0);
    settle();
    chk("after_wrap_count", bus.count, 16'h0001);

    step(1, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h0);
    settle();
    chk("wrap_dn_count", bus.count, 16'h9999);
    chk("wrap_dn_carry", bus.carry, 1);

    step(0, 0, 0, 1, 16'hF3A1);
    settle();
    chk("clamp_load", bus.count, 16'h9391);
    step(1, 1, 1, 1, 16'hF3A1);
    settle();
    chk("clr_beats_load", bus.count, 16'h0000);

    step(0, 0, 0, 1, 16'h1234);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 16'h0);
    settle();
    chk("hold_count", bus.count, 16'h1234);

    step(0, 0, 0, 1, 16'h0007);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 16'h0);

    // load and tick coinciding: prescaler sits at TD-1 before the load
    for (int i = 0; i < TD - 1; i++) step(1, 1, 0, 0, 16'h0);
    step(1, 1, 0, 1, 16'h0042);
    settle();
    chk("load_beats_tick", bus.count, 16'h0042);

    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 16'h0);
    do_reset();

    dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      case ($urandom_range(0, 4))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        2:       lv = 16'h9998;
        3:       lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      step(($urandom_range(0, 9) != 0), dir, (r < 3), (r >= 3 && r < 10), lv);
    end
    settle();
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
